uart_tx_cfg: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO, a runtime-selectable baud divisor and configurable frame format (data bits, stop bits, optional parity). It is the next-generation TX path for the uart_spi FPGA design. Host logic pushes words through a valid/ready port and the block serialises them LSB-first with no idle gap between queued frames.

---
 rtl/uart_tx_cfg.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// UART transmitter with integrated TX FIFO, runtime baud divisor and frame format.
// Optional parity stage is compiled in with `define UART_TX_PARITY_EN.

// Generic single-clock FIFO; registered level, combinational head read.
// Latency: a pushed word is visible at rd_dat / level one cycle after the push edge.
// Backpressure: push is ignored when full, pop is ignored when empty.
module uart_tx_cfg_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wr_dat,
  input  logic                     pop,
  output logic [W-1:0]             rd_dat,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && (level_q != FULL);
    do_pop   = pop && (level_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_dat;
  end

  assign rd_dat = mem_q[rd_ptr_q];
  assign level  = level_q;
endmodule

// Serialises queued words LSB-first: start, data, optional parity, stop bits.
// Latency: tx falls on the edge after the push into an empty idle block; frames run back-to-back.
// Backpressure: ready drops while the FIFO holds FIFO_DEPTH words (and for the reset cycle).
module uart_tx_cfg #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 921600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          valid,
  output logic                          ready,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    parity_mode,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV = (CLK_HZ + BAUD/2) / BAUD;
  localparam logic [DIV_W-1:0] DIV_V    = DIV_W'(DIV);
  localparam logic [LW-1:0]    FULL     = LW'(FIFO_DEPTH);
  localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS-1);
  localparam logic             LAST_STP = 1'(STOP_BITS-1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       cnt_q, cnt_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [3:0]             bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   rdy_en_q;
`ifdef UART_TX_PARITY_EN
  logic                   par_en_q, par_en_d;
  logic                   par_bit_q, par_bit_d;
`else
  logic                   unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
`endif

  logic                   push, pop, start_frame, bit_end, fifo_nempty;
  logic [DATA_BITS-1:0]   head;
  logic [DIV_W-1:0]       eff_div;

  uart_tx_cfg_fifo #(
    .W     (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .wr_dat (data),
    .pop    (pop),
    .rd_dat (head),
    .level  (fifo_level)
  );

  assign ready       = rdy_en_q && (fifo_level != FULL);
  assign push        = valid && ready;
  assign fifo_nempty = (fifo_level != '0);
  assign eff_div     = (baud_div == '0) ? DIV_V : baud_div;
  assign bit_end     = (cnt_q == '0);
  assign pop         = start_frame;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
`endif

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (fifo_nempty) start_frame = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = div_q - DIV_W'(1);
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = div_q - DIV_W'(1);
          if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = S_STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
`else
            state_d = S_STOP;
            stop_d  = 1'b0;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 4'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = div_q - DIV_W'(1);
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (stop_q == LAST_STP) begin
            // Chain straight into the next start bit when a word is waiting.
            if (fifo_nempty) begin
              start_frame = 1'b1;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            stop_d = 1'b1;
            cnt_d  = div_q - DIV_W'(1);
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Frame configuration is captured only here, so mid-frame input changes are ignored.
    if (start_frame) begin
      state_d = S_START;
      shift_d = head;
      div_d   = eff_div;
      cnt_d   = eff_div - DIV_W'(1);
      tx_d    = 1'b0;
      busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_d = (parity_mode != 2'b00);
      case (parity_mode)
        2'b01:   par_bit_d = ^head;
        2'b10:   par_bit_d = ~^head;
        2'b11:   par_bit_d = 1'b1;
        default: par_bit_d = 1'b0;
      endcase
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_q     <= DIV_V;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      rdy_en_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      rdy_en_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: driver queues accepted words, a line monitor decodes frames.
module tb_uart_tx_cfg;
  localparam int DB     = 7;
  localparam int SB     = 2;
  localparam int FD     = 4;
  localparam int DW     = 16;
  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 125000;
  localparam int DIVX   = (CLK_HZ + BAUD/2) / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DB-1:0] data = '0;
  logic          valid = 1'b0;
  logic          ready;
  logic [DW-1:0] baud_div = '0;
  logic [1:0]    parity_mode = 2'b00;
  logic          tx, busy;
  logic [$clog2(FD):0] fifo_level;

  uart_tx_cfg #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DB), .STOP_BITS(SB),
    .DIV_W(DW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .valid(valid), .ready(ready),
    .baud_div(baud_div), .parity_mode(parity_mode), .tx(tx), .busy(busy),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [DB-1:0] exp_q[$];
  int n_push = 0, nframes = 0, lvl_err = 0, idle_err = 0;

  task automatic chk_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Configuration as seen by the DUT at the most recent active edge.
  logic [DW-1:0] bd_s = '0;
  logic [1:0]    pm_s = '0;
  always @(posedge clk) begin
    bd_s <= baud_div;
    pm_s <= parity_mode;
  end

  // Line monitor: reference frame built from the frame rules, compared every cycle.
  bit   mon_en = 0, in_frame = 0, gap_pend = 0, exp_next = 0;
  logic bits [0:15];
  int   nb, d, cyc, total, ferr;
  logic [DB-1:0] w;
  always @(negedge clk) begin
    if (!mon_en) begin
      in_frame = 0;
      gap_pend = 0;
    end else begin
      if (gap_pend) begin
        gap_pend = 0;
        if (exp_next) chk_eq("b2b_start_tx", int'(tx), 0);
        else chk_eq("idle_busy_after_frame", int'(busy), 0);
      end
      if (!in_frame && tx == 1'b0) begin
        chk_eq("start_has_word", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) w = exp_q.pop_front();
        else w = '0;
        d  = (bd_s == 0) ? DIVX : int'(bd_s);
        nb = 0;
        bits[nb++] = 1'b0;
        for (int i = 0; i < DB; i++) bits[nb++] = w[i];
        if (PAR_EN != 0 && pm_s != 2'b00) begin
          if (pm_s == 2'b01) bits[nb++] = ^w;
          else if (pm_s == 2'b10) bits[nb++] = ~^w;
          else bits[nb++] = 1'b1;
        end
        for (int i = 0; i < SB; i++) bits[nb++] = 1'b1;
        total    = d * nb;
        cyc      = 0;
        ferr     = 0;
        in_frame = 1;
      end
      if (in_frame) begin
        if (tx !== bits[cyc / d] || busy !== 1'b1) ferr++;
        cyc++;
        if (cyc == total) begin
          chk_eq("frame_bad_samples", ferr, 0);
          in_frame = 0;
          gap_pend = 1;
          exp_next = (exp_q.size() > 0);
          nframes++;
        end
      end else if (busy !== 1'b0) begin
        idle_err++;
      end
      if (int'(fifo_level) != exp_q.size() || ready !== (exp_q.size() != FD)) lvl_err++;
    end
  end

  task automatic send(input logic [DB-1:0] word, output int stalls);
    bit acc, done;
    data   = word;
    valid  = 1'b1;
    stalls = 0;
    done   = 0;
    acc    = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      acc = ready;
      @(posedge clk);
      #1;
      if (acc) begin
        exp_q.push_back(word);
        n_push++;
        done = 1;
      end else begin
        stalls++;
      end
    end
    if (!done) chk_eq("send_accepted", int'(acc), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && busy == 1'b0) break;
    end
    chk_eq("drain_busy", int'(busy), 0);
    chk_eq("drain_queue", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic measure_frame(output int len);
    len = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy) break;
    end
    while (busy && len < 5000) begin
      len++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  int st, len, first_stall, zeros;
  logic [DB-1:0] rw;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_tx", int'(tx), 1);
    chk_eq("rst_busy", int'(busy), 0);
    chk_eq("rst_level", int'(fifo_level), 0);
    chk_eq("rst_ready", int'(ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1;
    @(negedge clk);
    chk_eq("ready_after_release", int'(ready), 1);
    @(posedge clk); #1;

    // Single word at default divisor, push-to-start latency
    send(7'h55, st);
    valid = 1'b0;
    @(negedge clk);
    chk_eq("lat_level_after_push", int'(fifo_level), 1);
    chk_eq("lat_tx_still_idle", int'(tx), 1);
    @(negedge clk);
    chk_eq("lat_tx_start", int'(tx), 0);
    chk_eq("lat_busy_start", int'(busy), 1);
    wait_idle();

    // Runtime divisor, mid-frame change ignored until next frame
    baud_div = 16'd4;
    send(7'h23, st);
    valid = 1'b0;
    fork
      begin
        repeat (10) @(posedge clk);
        #1 baud_div = 16'd9;
      end
    join_none
    measure_frame(len);
    chk_eq("div4_frame_len", len, 40);
    wait_idle();
    send(7'h23, st);
    valid = 1'b0;
    measure_frame(len);
    chk_eq("div9_frame_len", len, 90);
    wait_idle();

    // FIFO fill with valid held, back-to-back frames
    baud_div = 16'd2;
    first_stall = -1;
    for (int i = 0; i < 6; i++) begin
      send(DB'(7'h10 + i), st);
      if (st > 0 && first_stall < 0) first_stall = i;
    end
    valid = 1'b0;
    chk_eq("fill_first_stall_idx", first_stall, 5);
    wait_idle();
    chk_eq("fill_level_zero", int'(fifo_level), 0);

    // Parity modes on 0x31
    baud_div = 16'd3;
    for (int m = 0; m < 4; m++) begin
      parity_mode = 2'(m);
      send(7'h31, st);
      valid = 1'b0;
      measure_frame(len);
      chk_eq("parity_frame_len", len, (m != 0 && PAR_EN != 0) ? 33 : 30);
      wait_idle();
    end
    parity_mode = 2'b00;

    // Reset during the third data bit with words queued
    send(7'h4B, st);
    send(7'h12, st);
    send(7'h34, st);
    valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) break;
    end
    repeat (10) @(negedge clk);
    rst_n  = 1'b0;
    mon_en = 0;
    exp_q.delete();
    @(negedge clk);
    chk_eq("midrst_tx", int'(tx), 1);
    chk_eq("midrst_busy", int'(busy), 0);
    chk_eq("midrst_level", int'(fifo_level), 0);
    chk_eq("midrst_ready", int'(ready), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1;
    zeros = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx == 1'b0) zeros++;
    end
    chk_eq("midrst_no_frame", zeros, 0);
    @(posedge clk); #1;

    // Push held at full across the pop edge
    baud_div = 16'd20;
    for (int i = 0; i < 5; i++) send(DB'(7'h60 + i), st);
    data = 7'h7E;
    @(negedge clk);
    chk_eq("full_ready_low", int'(ready), 0);
    chk_eq("full_level", int'(fifo_level), FD);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (fifo_level != FD) break;
    end
    chk_eq("pop_level_dec", int'(fifo_level), FD - 1);
    chk_eq("pop_ready_high", int'(ready), 1);
    @(posedge clk); #1;
    exp_q.push_back(7'h7E);
    n_push++;
    valid = 1'b0;
    @(negedge clk);
    chk_eq("refill_level", int'(fifo_level), FD);
    @(posedge clk); #1;
    wait_idle();

    // Randomized words, divisors and parity modes
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: baud_div = 16'd0;
        1: baud_div = 16'd1;
        2: baud_div = 16'd2;
        3: baud_div = 16'd3;
        default: baud_div = 16'd5;
      endcase
      parity_mode = 2'($urandom_range(0, 3));
      rw = DB'($urandom_range(0, (1 << DB) - 1));
      send(rw, st);
      if ($urandom_range(0, 2) == 0) begin
        valid = 1'b0;
        repeat ($urandom_range(0, 30)) @(posedge clk);
        #1;
      end
    end
    valid = 1'b0;
    wait_idle();

    chk_eq("level_ready_track_errs", lvl_err, 0);
    chk_eq("idle_busy_errs", idle_err, 0);
    chk_eq("frames_completed", nframes, n_push - 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
